// File: rtl/uart_tx_frm.sv
// UART transmitter with elaboration-time data width, parity and stop-bit count, and a
// one-word holding register so frames can be sent back-to-back.
module uart_tx_frm #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0] StopLast = 4'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("uart_tx_frm: CLKS_PER_BIT must be 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_frm: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_frm: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frm: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        clk_cnt_q;
  logic [3:0]             bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   hold_q;
  logic                   hold_full_q;
  logic                   parity_q;
  logic                   ready_q;
  logic                   serial_q;
  logic                   active_q;
  logic                   stop_end_q;
  logic                   done_q;

  logic bit_end;
  logic accept;
  logic load;
  logic parity_calc;

  assign bit_end     = (clk_cnt_q == CntLast);
  assign accept      = i_Tx_DV && ready_q;
  assign parity_calc = (PARITY_MODE == 1) ? ~^hold_q : ^hold_q;

  always_comb begin
    load = 1'b0;
    unique case (state_q)
      StIdle:  load = hold_full_q;
      StStop:  load = hold_full_q && bit_end && (bit_cnt_q == StopLast);
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= StIdle;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      parity_q    <= 1'b0;
      ready_q     <= 1'b1;
      serial_q    <= 1'b1;
      active_q    <= 1'b0;
      stop_end_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // accept and load are exclusive: load needs a full holding register, so ready_q is 0
      if (accept) begin
        hold_q      <= i_Tx_Byte;
        hold_full_q <= 1'b1;
        ready_q     <= 1'b0;
      end else if (load) begin
        hold_full_q <= 1'b0;
        ready_q     <= 1'b1;
      end

      // line and status outputs follow the state one cycle later
      unique case (state_q)
        StIdle:   serial_q <= 1'b1;
        StStart:  serial_q <= 1'b0;
        StData:   serial_q <= shift_q[0];
        StParity: serial_q <= parity_q;
        default:  serial_q <= 1'b1;
      endcase
      active_q   <= (state_q != StIdle) || hold_full_q;
      done_q     <= stop_end_q;
      stop_end_q <= 1'b0;

      if (load) begin
        shift_q   <= hold_q;
        parity_q  <= parity_calc;
        state_q   <= StStart;
        clk_cnt_q <= '0;
        bit_cnt_q <= '0;
        if (state_q == StStop) stop_end_q <= 1'b1;
      end else if (state_q != StIdle) begin
        clk_cnt_q <= bit_end ? '0 : clk_cnt_q + 1'b1;
        if (bit_end) begin
          unique case (state_q)
            StStart: state_q <= StData;
            StData: begin
              shift_q <= shift_q >> 1;
              if (bit_cnt_q == DataLast) begin
                bit_cnt_q <= '0;
                state_q   <= (PARITY_MODE != 0) ? StParity : StStop;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
            StParity: state_q <= StStop;
            StStop: begin
              if (bit_cnt_q == StopLast) begin
                state_q    <= StIdle;
                bit_cnt_q  <= '0;
                stop_end_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

  assign o_Tx_Ready  = ready_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Done   = done_q;

endmodule
